// File: rtl/hh_neuron_array.sv
// N-channel integrate/leak/fire neuron array, one channel per clock.
// Optional per-channel adaptive threshold: define SPIKE_ADAPT_EN.
module hh_neuron_array #(
  parameter int N            = 4,
  parameter int W            = 8,
  parameter int TH           = 32,
  parameter int V_REST       = 0,
  parameter int V_RESET      = 0,
  parameter int LEAK_SHIFT   = 2,
  parameter int DT_SHIFT     = 2,
  parameter int REFRAC_STEPS = 2,
  parameter int TH_INC       = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             step_valid,
  output logic                             step_ready,
  input  logic [N*W-1:0]                   stim,
  output logic                             done,
  output logic [N-1:0]                     spike_vec,
  input  logic [((N>1)?$clog2(N):1)-1:0]   rd_sel,
  output logic [W-1:0]                     v_rd,
  output logic [15:0]                      spike_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = W + 2;
  localparam int RW = (REFRAC_STEPS > 0) ?
                      $clog2(REFRAC_STEPS + 1) : 1;
  localparam logic signed [XW-1:0] VREST_X = XW'(V_REST);
  localparam logic signed [XW-1:0] VMAX_X  = XW'((1 << W) - 1);
  localparam logic [IW-1:0]        LAST    = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [IW-1:0]  idx;
  logic [N*W-1:0] stim_q;
  logic [W-1:0]   v_mem [N];
  logic [RW-1:0]  rf_mem [N];
  logic [N-1:0]   shadow, shadow_nx;
  logic           accept, last, running;

  logic [W-1:0]          v_cur, s_cur, thr_cur, v_new, nv;
  logic [RW-1:0]         rf_cur, rf_new;
  logic signed [XW-1:0]  v_x, s_x, leak, delta, nv_x;
  logic                  fire, refrac;
  logic [16:0]           pop, cnt_sum;

  assign running = (state_q == RUN);
  assign last    = (idx == LAST);
  assign accept  = step_valid && step_ready;

  always_comb begin
    state_d    = state_q;
    step_ready = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        step_ready = 1'b1;
        if (step_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        step_ready = 1'b1;
        done       = 1'b1;
        state_d    = step_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared datapath: W+2 signed bits keep V - V_REST and stim - leak exact
  always_comb begin
    v_cur  = v_mem[idx];
    s_cur  = stim_q[idx*W +: W];
    rf_cur = rf_mem[idx];
    v_x    = {2'b00, v_cur};
    s_x    = {{2{s_cur[W-1]}}, s_cur};
    leak   = (v_x - VREST_X) >>> LEAK_SHIFT;
    delta  = (s_x - leak) >>> DT_SHIFT;
    nv_x   = v_x + delta;
    if (nv_x[XW-1])         nv = '0;
    else if (nv_x > VMAX_X) nv = '1;
    else                    nv = nv_x[W-1:0];
    refrac = (rf_cur != '0);
    fire   = !refrac && (nv >= thr_cur);
    v_new  = nv;
    rf_new = rf_cur;
    if (refrac) begin
      v_new  = W'(V_RESET);
      rf_new = rf_cur - RW'(1);
    end else if (fire) begin
      v_new  = W'(V_RESET);
      rf_new = RW'(REFRAC_STEPS);
    end
    shadow_nx      = shadow;
    shadow_nx[idx] = fire;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + 17'(shadow_nx[i]);
    cnt_sum = {1'b0, spike_cnt} + pop;
  end

`ifdef SPIKE_ADAPT_EN
  logic [W-1:0] thr_mem [N];
  logic [W-1:0] thr_new;
  logic [W:0]   thr_sum;

  assign thr_cur = thr_mem[idx];

  always_comb begin
    thr_sum = {1'b0, thr_cur} + (W+1)'(TH_INC);
    thr_new = thr_cur;
    if (fire)
      thr_new = thr_sum[W] ? '1 : thr_sum[W-1:0];
    else if (!refrac && (thr_cur > W'(TH)))
      thr_new = thr_cur - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) thr_mem[i] <= W'(TH);
    end else if (running) begin
      thr_mem[idx] <= thr_new;
    end
  end
`else
  assign thr_cur = W'(TH);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx       <= '0;
      stim_q    <= '0;
      shadow    <= '0;
      spike_vec <= '0;
      spike_cnt <= '0;
      v_rd      <= '0;
      for (int i = 0; i < N; i++) begin
        v_mem[i]  <= W'(V_REST);
        rf_mem[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        stim_q <= stim;
        idx    <= '0;
        shadow <= '0;
      end else if (running) begin
        idx         <= idx + IW'(1);
        shadow      <= shadow_nx;
        v_mem[idx]  <= v_new;
        rf_mem[idx] <= rf_new;
      end
      if (running && last) begin
        spike_vec <= shadow_nx;
        spike_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
      // Bypass so a channel reads back its new value right after its update
      if (running && (rd_sel == idx))
        v_rd <= v_new;
      else if (int'(rd_sel) < N)
        v_rd <= v_mem[rd_sel];
      else
        v_rd <= '0;
    end
  end

endmodule

// File: tb/tb_hh_neuron_array.sv
// Directed table-driven bench for hh_neuron_array (N=4, W=8).
module tb_hh_neuron_array;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [31:0] stim;
    logic [1:0]  rd;
    logic [3:0]  spk;
    logic [7:0]  v;
    logic [15:0] cnt;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           step_valid = 1'b0;
  logic           step_ready;
  logic [N*W-1:0] stim = '0;
  logic           done;
  logic [N-1:0]   spike_vec;
  logic [1:0]     rd_sel = '0;
  logic [W-1:0]   v_rd;
  logic [15:0]    spike_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hh_neuron_array dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .stim       (stim),
    .done       (done),
    .spike_vec  (spike_vec),
    .rd_sel     (rd_sel),
    .v_rd       (v_rd),
    .spike_cnt  (spike_cnt)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    step_valid = 1'b0;
    stim       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stim is scrambled after accept: a correct DUT uses the latched copy
  task automatic do_step(input  logic [31:0] s,
                         output logic [3:0]  sv,
                         output logic [7:0]  vr,
                         output logic [15:0] cn,
                         output int          lat);
    step_valid = 1'b1;
    stim       = s;
    @(negedge clk);
    step_valid = 1'b0;
    stim       = ~s;
    lat        = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    sv = spike_vec;
    vr = v_rd;
    cn = spike_cnt;
    stim = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [12];
    logic [3:0]  sv;
    logic [7:0]  vr;
    logic [15:0] cn;
    int          lat;
    int          last_done;
    int          nd;
    int          lowrun;
    logic        saw_done;
    logic [3:0]  e10s, e11s;
    logic [7:0]  e10v, e11v;

    tbl[0]  = '{32'h00000028, 2'd0, 4'h0, 8'd10, 16'd0};
    tbl[1]  = '{32'h00000028, 2'd0, 4'h0, 8'd19, 16'd0};
    tbl[2]  = '{32'h00000028, 2'd0, 4'h0, 8'd28, 16'd0};
    tbl[3]  = '{32'h00000028, 2'd0, 4'h1, 8'd0,  16'd1};
    tbl[4]  = '{32'h00000028, 2'd0, 4'h0, 8'd0,  16'd1};
    tbl[5]  = '{32'h00000028, 2'd0, 4'h0, 8'd0,  16'd1};
    tbl[6]  = '{32'h00000028, 2'd0, 4'h0, 8'd10, 16'd1};
    tbl[7]  = '{32'h00800000, 2'd2, 4'h0, 8'd0,  16'd1};
    tbl[8]  = '{32'h7F000000, 2'd3, 4'h0, 8'd31, 16'd1};
    tbl[9]  = '{32'h7F000000, 2'd3, 4'h8, 8'd0,  16'd2};
    tbl[10] = '{32'h00007C00, 2'd1, 4'h0, 8'd31, 16'd2};
    tbl[11] = '{32'h00000B00, 2'd1, 4'h2, 8'd0,  16'd3};

`ifdef SPIKE_ADAPT_EN
    e10s = 4'h0; e10v = 8'd36; e11s = 4'h1; e11v = 8'd0;
`else
    e10s = 4'h1; e10v = 8'd0;  e11s = 4'h0; e11v = 8'd0;
`endif

    // Reset state
    do_reset();
    check("rst_ready", 32'(step_ready), 32'd1);
    check("rst_done",  32'(done),       32'd0);
    check("rst_spk",   32'(spike_vec),  32'd0);
    check("rst_vrd",   32'(v_rd),       32'd0);
    check("rst_cnt",   32'(spike_cnt),  32'd0);

    // Integrate/fire, refractory, clamps, exact-threshold spike
    for (int i = 0; i < 12; i++) begin
      rd_sel = tbl[i].rd;
      do_step(tbl[i].stim, sv, vr, cn, lat);
      check($sformatf("lat_%0d", i), 32'(lat), 32'(N + 1));
      check($sformatf("spk_%0d", i), 32'(sv), 32'(tbl[i].spk));
      check($sformatf("v_%0d", i),   32'(vr), 32'(tbl[i].v));
      check($sformatf("cnt_%0d", i), 32'(cn), 32'(tbl[i].cnt));
    end

    // Back-to-back steps with step_valid held high
    step_valid = 1'b1;
    stim       = '0;
    last_done  = -1;
    nd         = 0;
    lowrun     = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin
        if (last_done >= 0)
          check("done_gap", 32'(c - last_done), 32'd5);
        else
          check("done_first", 32'(c), 32'd4);
        last_done = c;
        nd++;
      end
      if (!step_ready) lowrun++;
      else begin
        if (lowrun > 0) check("ready_low", 32'(lowrun), 32'd4);
        lowrun = 0;
      end
    end
    step_valid = 1'b0;
    check("done_count", 32'(nd), 32'd6);
    repeat (3) @(negedge clk);

    // Threshold behaviour on a long ch0 drive from reset
    do_reset();
    rd_sel = 2'd0;
    for (int k = 1; k <= 11; k++) begin
      do_step(32'h00000028, sv, vr, cn, lat);
      if (k == 10) begin
        check("thr_spk10", 32'(sv), 32'(e10s));
        check("thr_v10",   32'(vr), 32'(e10v));
      end
      if (k == 11) begin
        check("thr_spk11", 32'(sv), 32'(e11s));
        check("thr_v11",   32'(vr), 32'(e11v));
        check("thr_cnt11", 32'(cn), 32'd2);
      end
    end

    // Reset in the middle of a sweep
    do_reset();
    rd_sel = 2'd1;
    do_step(32'h28282828, sv, vr, cn, lat);
    check("pre_v1", 32'(vr), 32'd10);
    step_valid = 1'b1;
    stim       = 32'h28282828;
    @(negedge clk);
    step_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_ready", 32'(step_ready), 32'd1);
    check("mid_done",  32'(done),       32'd0);
    check("mid_cnt",   32'(spike_cnt),  32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("mid_nodone", 32'(saw_done), 32'd0);
    for (int i = 0; i < N; i++) begin
      rd_sel = 2'(i);
      @(negedge clk);
      check($sformatf("mid_v%0d", i), 32'(v_rd), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
